// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the completer FSM state encoding.
// Used by both the completer and any master in the same bench or SoC.
// Contains no logic.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between one master and one completer on a single PSELx line.
// There is no latency of its own; it is wires only.
// The completer stalls the master by holding PREADY low.
interface apb_if;
  import apb_pkg::*;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_STRB_W-1:0] PSTRB;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_regfile.sv
// Register array with a byte-strobed write port and a combinational read port.
// Writes land on the clock edge. Reads have zero latency.
// There is no backpressure. The top index is the constant ID register and has no storage.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int              NUM_REGS = 16,
  parameter logic [31:0]     ID_VALUE = 32'hA5B0_0001,
  localparam int             IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_STRB_W-1:0] wstrb,
  input  logic [IDX_W-1:0]      raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

  logic [APB_DATA_W-1:0] regs [NUM_REGS-1];

  // Clear the array on reset. Otherwise update only the enabled byte lanes of writable entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS - 1; r++) regs[r] <= '0;
    end else if (we && (waddr < ID_IDX)) begin
      for (int i = 0; i < APB_STRB_W; i++) begin
        if (wstrb[i]) regs[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = (raddr < ID_IDX) ? regs[raddr] : ID_VALUE;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer that fronts apb_regfile and decodes a single address window.
// A transfer takes 2+WAIT_CYCLES cycles from setup, with PREADY high for one cycle.
// It stalls the master with PREADY low. If the master drops PSEL, the transfer is abandoned silently.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_if.slave bus
);

  localparam int             IDX_W  = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

  apb_state_t            state;
  logic [3:0]            cnt;
  logic [APB_ADDR_W-1:0] addr_q;
  logic                  write_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_STRB_W-1:0] strb_q;

  // Sequence the setup and access phases and capture the transfer at setup.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            addr_q  <= bus.PADDR;
            write_q <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
            strb_q  <= bus.PSTRB;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.PSEL) begin
            state <= IDLE;
          end else if (bus.PENABLE) begin
            if (cnt != 4'd0) cnt   <= cnt - 4'd1;
            else             state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decode the latched address. The extra top bit of the subtraction is the borrow, which flags addresses below the window.
  logic [APB_ADDR_W:0]   diff;
  logic [APB_ADDR_W-1:0] offset;
  logic [IDX_W-1:0]      index;
  logic                  err;

  assign diff   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign offset = diff[APB_ADDR_W-1:0];
  assign index  = offset[IDX_W+1:2];
  assign err    = diff[APB_ADDR_W]
               || (offset >= 32'(4 * NUM_REGS))
               || (addr_q[1:0] != 2'b00)
               || (write_q && (index == ID_IDX));

  // Complete only while the master still holds the access phase, so an abort can never produce a response.
  logic                  done;
  logic [APB_DATA_W-1:0] rf_rdata;

  assign done = (state == ACCESS) && (cnt == 4'd0) && bus.PSEL && bus.PENABLE && !PRESET;

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (done && write_q && !err),
    .waddr (index),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .raddr (index),
    .rdata (rf_rdata)
  );

  assign bus.PREADY  = done;
  assign bus.PSLVERR = done && err;
  assign bus.PRDATA  = (done && !write_q && !err) ? rf_rdata : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile.
// Three instances (WAIT_CYCLES 1, 0 and 3) share one master; sel picks the one PSEL reaches.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] ID   = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  int          sel;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int t_start, t_end;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  apb_if b0 ();
  apb_if b1 ();
  apb_if b2 ();

  assign b0.PSEL = psel && (sel == 0);
  assign b1.PSEL = psel && (sel == 1);
  assign b2.PSEL = psel && (sel == 2);
  assign {b0.PENABLE, b0.PWRITE, b0.PADDR, b0.PWDATA, b0.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};
  assign {b1.PENABLE, b1.PWRITE, b1.PADDR, b1.PWDATA, b1.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};
  assign {b2.PENABLE, b2.PWRITE, b2.PADDR, b2.PWDATA, b2.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};

  apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_CYCLES(1), .ID_VALUE(ID))
    dut0 (.PCLK(clk), .PRESET(rst), .bus(b0));
  apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(ID))
    dut1 (.PCLK(clk), .PRESET(rst), .bus(b1));
  apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_CYCLES(3), .ID_VALUE(ID))
    dut2 (.PCLK(clk), .PRESET(rst), .bus(b2));

  always_comb begin
    case (sel)
      0:       begin prdata = b0.PRDATA; pready = b0.PREADY; pslverr = b0.PSLVERR; end
      1:       begin prdata = b1.PRDATA; pready = b1.PREADY; pslverr = b1.PSLVERR; end
      default: begin prdata = b2.PRDATA; pready = b2.PREADY; pslverr = b2.PSLVERR; end
    endcase
  end

  function automatic int waits(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // A complete APB transfer on the selected instance. It returns the response and the cycle index of PREADY, counting the setup cycle as 1.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic er, output int n);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    t_start = cyc_cnt;
    n = 1;
    rd = 'x; er = 1'bx;
    @(negedge clk);
    chk("setup_no_ready", {31'b0, pready}, 32'd0);
    forever begin
      @(posedge clk); #1;
      penable = 1'b1;
      n++;
      @(negedge clk);
      if (pready) begin
        rd = prdata; er = pslverr; t_end = cyc_cnt;
        break;
      end
      if (n > 40) begin
        errors++; checks++;
        $display("FAIL timeout: no PREADY after %0d cycles, required within 17", n);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    int          dut;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [16];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;

    vt[0]  = '{0, 1'b1, BASE + 32'h04, 32'h1234_5678, 4'b1111, 32'h0, 1'b0};
    vt[1]  = '{0, 1'b0, BASE + 32'h04, 32'h0,         4'b0000, 32'h1234_5678, 1'b0};
    vt[2]  = '{0, 1'b1, BASE + 32'h08, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b0};
    vt[3]  = '{0, 1'b0, BASE + 32'h08, 32'h0,         4'b1111, 32'h00FF_00FF, 1'b0};
    vt[4]  = '{0, 1'b0, BASE + 32'h40, 32'h0,         4'b0000, 32'h0, 1'b1};
    vt[5]  = '{0, 1'b1, BASE + 32'h02, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b1};
    vt[6]  = '{0, 1'b0, BASE + 32'h00, 32'h0,         4'b0000, 32'h0, 1'b0};
    vt[7]  = '{0, 1'b1, BASE + 32'h3C, 32'h0BAD_0BAD, 4'b1111, 32'h0, 1'b1};
    vt[8]  = '{0, 1'b0, BASE + 32'h3C, 32'h0,         4'b0000, ID,    1'b0};
    vt[9]  = '{0, 1'b0, BASE - 32'h04, 32'h0,         4'b0000, 32'h0, 1'b1};
    vt[10] = '{0, 1'b1, BASE + 32'h0C, 32'h1122_3344, 4'b0000, 32'h0, 1'b0};
    vt[11] = '{0, 1'b0, BASE + 32'h0C, 32'h0,         4'b0000, 32'h0, 1'b0};
    vt[12] = '{1, 1'b1, BASE + 32'h00, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0};
    vt[13] = '{1, 1'b0, BASE + 32'h00, 32'h0,         4'b0000, 32'hCAFE_F00D, 1'b0};
    vt[14] = '{2, 1'b1, BASE + 32'h10, 32'hA5A5_A5A5, 4'b1100, 32'h0, 1'b0};
    vt[15] = '{2, 1'b0, BASE + 32'h10, 32'h0,         4'b0000, 32'hA5A5_0000, 1'b0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel = 0;

    // Outputs held at zero while in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      chk($sformatf("reset_out_d%0d", d), {prdata[31:2], prdata[1:0] | {pready, pslverr}}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven transfers
    for (int i = 0; i < 16; i++) begin
      sel = vt[i].dut;
      xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, n);
      chk($sformatf("v%0d_cycles", i), n, 2 + waits(vt[i].dut));
      chk($sformatf("v%0d_pslverr", i), {31'b0, er}, {31'b0, vt[i].exp_err});
      chk($sformatf("v%0d_prdata", i), rd, vt[i].exp_rd);
    end
    idle();

    // Four back-to-back writes occupy exactly 4*(2+WAIT_CYCLES) cycles, then read them back.
    for (int d = 1; d < 3; d++) begin
      int first;
      sel = d;
      for (int k = 0; k < 4; k++) begin
        xfer(1'b1, BASE + 32'h20 + 32'(4 * k), 32'h5000_0000 + 32'(k), 4'b1111, rd, er, n);
        if (k == 0) first = t_start;
      end
      chk($sformatf("b2b_span_d%0d", d), t_end - first + 1, 4 * (2 + waits(d)));
      for (int k = 0; k < 4; k++) begin
        xfer(1'b0, BASE + 32'h20 + 32'(4 * k), 32'h0, 4'b0000, rd, er, n);
        chk($sformatf("b2b_rd_d%0d_%0d", d, k), rd, 32'h5000_0000 + 32'(k));
      end
      idle();
    end

    // A PENABLE=1 seen in IDLE without a setup phase must never complete or write.
    sel = 1;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = BASE; pwdata = 32'h0; pstrb = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      chk("idle_penable_no_ready", {31'b0, pready}, 32'd0);
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    xfer(1'b0, BASE, 32'h0, 4'b0000, rd, er, n);
    chk("idle_penable_unchanged", rd, 32'hCAFE_F00D);
    idle();

    // Abort during the wait states of the WAIT_CYCLES=3 instance.
    sel = 2;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h10; pwdata = 32'hFFFF_FFFF; pstrb = 4'b1111;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ready", {31'b0, pready}, 32'd0);
      @(posedge clk); #1;
    end
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'b0000, rd, er, n);
    chk("abort_unchanged", rd, 32'hA5A5_0000);
    idle();

    // Abort on instance 0 exactly when its counter has reached zero.
    sel = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h04; pwdata = 32'h0; pstrb = 4'b1111;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel = 1'b0;
    @(negedge clk);
    chk("abort_cnt0_no_ready", {31'b0, pready}, 32'd0);
    xfer(1'b0, BASE + 32'h04, 32'h0, 4'b0000, rd, er, n);
    chk("abort_cnt0_unchanged", rd, 32'h1234_5678);
    idle();

    // Reset lands in the cycle where instance 0 would otherwise complete a write.
    sel = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h14; pwdata = 32'h7777_7777; pstrb = 4'b1111;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, pready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_out", {prdata[31:2], prdata[1:0] | {pready, pslverr}}, 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int r = 0; r < 16; r++) begin
      xfer(1'b0, BASE + 32'(4 * r), 32'h0, 4'b0000, rd, er, n);
      chk($sformatf("rst_reg%0d", r), rd, (r == 15) ? ID : 32'h0);
    end
    sel = 2;
    xfer(1'b0, BASE + 32'h10, 32'h0, 4'b0000, rd, er, n);
    chk("rst_d2_reg4", rd, 32'h0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to end earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that answers transfers from the APB master with a byte-strobed register file. It decodes one address window, supports a parameterised number of wait states, and returns PREADY, PRDATA and PSLVERR. It sits on one PSELx line of the master and is the block-level endpoint for bus bring-up and register-access tests.

## Interface

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of register 0.
- NUM_REGS, 16: number of 32-bit registers, 2..256; register NUM_REGS-1 is the read-only ID register.
- WAIT_CYCLES, 1: wait states inserted before PREADY, 0..15.
- ID_VALUE, 32'hA5B0_0001: constant returned by the ID register.

Ports:
- PCLK  in  1  clock. Everything is sampled on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte lanes. PSTRB[i] enables PWDATA[8i+7:8i].
- PRDATA  out  32  read data. Valid only while PREADY=1 on a read, otherwise 0.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response. Valid only while PREADY=1, otherwise 0.

## Operation

- State machine `IDLE` → `ACCESS` → `IDLE`:
  - `IDLE`: if PSEL=1 and PENABLE=0 (setup phase):
    - latch PADDR, PWRITE, PWDATA and PSTRB;
    - load the wait counter with WAIT_CYCLES;
    - go to `ACCESS`.
  - `ACCESS`, PSEL=1 and PENABLE=1, counter>0: decrement the counter.
  - `ACCESS`, PSEL=1 and PENABLE=1, counter=0: assert PREADY, commit the transfer, go to `IDLE`.
  - `ACCESS` with PSEL=0 (master aborted): return to `IDLE`. No write occurs, no response is given.
- Decode, performed on the latched address:
  - offset = addr − BASE_ADDR;
  - index = offset[..:2].
  - err = 1 if any of the following holds:
    - addr < BASE_ADDR;
    - offset ≥ 4·NUM_REGS;
    - addr[1:0] ≠ 0;
    - the transfer is a write to index NUM_REGS-1.
- Write commit, when PREADY=1 and err=0: for each lane i with PSTRB[i]=1, regs[index][8i+7:8i] ← PWDATA lane. Lanes with PSTRB[i]=0 are unchanged. PSTRB=0 is legal and changes nothing.
- Read, when PREADY=1 and err=0:
  - PRDATA = regs[index];
  - the ID register returns ID_VALUE.
- Any error: PSLVERR=1 with PREADY. No register changes. PRDATA=0.
- Reads ignore PSTRB.

## Timing

- Reset values: state = `IDLE`, counter = 0, all registers 0 except ID, PREADY = 0, PSLVERR = 0, PRDATA = 0.
- PRESET asserted mid-transfer: the next edge goes to `IDLE`, the in-flight write is dropped, and outputs are 0 from that cycle on.
- Completion: PREADY is high for exactly one cycle. The transfer occupies 2+WAIT_CYCLES cycles, counting from the setup cycle.
- PREADY, PRDATA and PSLVERR are combinational from the state, the counter and the latched registers. They do not depend on the current PADDR or PWDATA.
- Back-to-back transfers: a setup phase in the cycle after PREADY is accepted with no bubble.
- Read-after-write to the same register returns the new value in the next transfer.
- A PENABLE=1 seen in `IDLE` without a prior setup phase is ignored.

## Structure

- Package `apb_pkg` holds:
  - the state enum (`IDLE`, `ACCESS`);
  - `APB_ADDR_W` = 32, `APB_DATA_W` = 32, `APB_STRB_W` = 4.
  These are shared with the master.
- Sub-module `apb_regfile` holds the NUM_REGS×32 array with a byte-strobed write port and a combinational read port.
- The top level contains the FSM, the wait counter, the decode logic and the response muxing.

## Test plan

- **Write then read, WAIT_CYCLES=1:**
  - Write 32'h1234_5678 to BASE+4 with PSTRB=4'b1111 → PREADY high on the 3rd cycle, PSLVERR=0.
  - Read BASE+4 → PRDATA=32'h1234_5678.
- **Partial strobe:** write 32'hFFFF_FFFF to BASE+8 with PSTRB=4'b0101 over a preset value of 0 → readback is 32'h00FF_00FF.
- **Errors:**
  - Read BASE+4·NUM_REGS → PSLVERR=1, PRDATA=0.
  - Write BASE+2 → PSLVERR=1, registers unchanged.
  - Write the ID register → PSLVERR=1. A subsequent read of the ID register returns 32'hA5B0_0001 with PSLVERR=0.
- **WAIT_CYCLES=0 and WAIT_CYCLES=3:** PREADY appears on the 2nd and 5th cycle of the transfer respectively. Four back-to-back writes complete with no idle gap.
- **Abort and reset:**
  - PSEL dropped during wait states → no PREADY, target register unchanged.
  - PRESET=1 asserted mid-ACCESS → outputs are 0 the next cycle and all registers read 0 afterwards.
